// File: rtl/axi_interface_master_if.sv
// AXI4 address/data/response channel bundle between the initiator engine and the fabric.
// Handshake rule on every channel: a beat transfers on a rising edge where valid && ready; once valid is high, it and its payload hold until that edge.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef LEN_BITS
`define LEN_BITS 8
`endif
`ifndef ID_BITS
`define ID_BITS 4
`endif

interface axi_interface_master_if;
  logic [`ID_BITS-1:0]      awid;
  logic [`ADDR_WIDTH-1:0]   awaddr;
  logic [`LEN_BITS-1:0]     awlen;
  logic [2:0]               awsize;
  logic [1:0]               awburst;
  logic                     awvalid;
  logic                     awready;
  logic [`DATA_WIDTH-1:0]   wdata;
  logic [`DATA_WIDTH/8-1:0] wstrb;
  logic                     wvalid;
  logic                     wlast;
  logic                     wready;
  logic [`ID_BITS-1:0]      bid;
  logic [2:0]               bresp;
  logic                     bvalid;
  logic                     bready;
  logic [`ID_BITS-1:0]      arid;
  logic [`ADDR_WIDTH-1:0]   araddr;
  logic [`LEN_BITS-1:0]     arlen;
  logic [2:0]               arsize;
  logic [1:0]               arburst;
  logic                     arvalid;
  logic                     arready;
  logic [`ID_BITS-1:0]      rid;
  logic [`DATA_WIDTH-1:0]   rdata;
  logic [2:0]               rresp;
  logic                     rvalid;
  logic                     rlast;
  logic                     rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    output wdata, wstrb, wvalid, wlast,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    output rready,
    input  awready, wready, bid, bresp, bvalid, arready,
    input  rid, rdata, rresp, rvalid, rlast
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    input  wdata, wstrb, wvalid, wlast,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    input  rready,
    output awready, wready, bid, bresp, bvalid, arready,
    output rid, rdata, rresp, rvalid, rlast
  );
endinterface

// File: rtl/axi_interface_master.sv
// Single-outstanding AXI4 initiator: turns one client burst command into an AW/W/B or AR/R
// exchange, streaming write and read beats straight through between client and bus.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef LEN_BITS
`define LEN_BITS 8
`endif
`ifndef ID_BITS
`define ID_BITS 4
`endif

module axi_interface_master #(
  parameter logic [`ID_BITS-1:0] MASTER_ID = '0,
  parameter int                  AXSIZE    = $clog2(`DATA_WIDTH/8)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_we,
  input  logic [`ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [`LEN_BITS-1:0]     cmd_len,
  input  logic                     wd_valid,
  output logic                     wd_ready,
  input  logic [`DATA_WIDTH-1:0]   wd_data,
  input  logic [`DATA_WIDTH/8-1:0] wd_strb,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [`DATA_WIDTH-1:0]   rd_data,
  output logic                     rd_last,
  output logic                     done,
  output logic [2:0]               resp,
  output logic [2:0]               dbg_state,
  axi_interface_master_if.master   axi
);
  localparam int LB = `LEN_BITS;

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R} state_e;

  state_e                 r_state, w_state_nxt;
  logic [`ADDR_WIDTH-1:0] r_addr;
  logic [LB-1:0]          r_len;
  logic [LB-1:0]          r_cnt;
  logic [2:0]             r_resp;
  logic [2:0]             r_err_resp;
  logic                   r_err;
  logic                   r_done;
  logic                   w_cnt_at_len;
  logic                   w_w_hs;
  logic                   w_r_hs;
  logic                   w_r_exit;
  logic [2:0]             w_r_resp;
  logic                   w_unused;

  assign w_unused     = ^{axi.bid, axi.rid};
  assign w_cnt_at_len = (r_cnt == r_len);
  assign w_w_hs       = (r_state == S_W) && wd_valid && axi.wready;
  assign w_r_hs       = (r_state == S_R) && axi.rvalid && rd_ready;
  assign w_r_exit     = w_r_hs && (axi.rlast || w_cnt_at_len);

  assign axi.awid    = MASTER_ID;
  assign axi.awaddr  = r_addr;
  assign axi.awlen   = r_len;
  assign axi.awsize  = 3'(AXSIZE);
  assign axi.awburst = 2'b01;
  assign axi.arid    = MASTER_ID;
  assign axi.araddr  = r_addr;
  assign axi.arlen   = r_len;
  assign axi.arsize  = 3'(AXSIZE);
  assign axi.arburst = 2'b01;
  assign axi.wdata   = wd_data;
  assign axi.wstrb   = wd_strb;
  assign rd_data     = axi.rdata;
  assign done        = r_done;
  assign resp        = r_resp;
  assign dbg_state   = r_state;

  // First error wins; otherwise an rlast that disagrees with the requested length is a slave error.
  always_comb begin
    w_r_resp = 3'b000;
    if (r_err)                        w_r_resp = r_err_resp;
    else if (axi.rresp != 3'b000)     w_r_resp = axi.rresp;
    else if (axi.rlast != w_cnt_at_len) w_r_resp = 3'b010;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    cmd_ready   = 1'b0;
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    axi.wlast   = 1'b0;
    axi.bready  = 1'b0;
    axi.arvalid = 1'b0;
    axi.rready  = 1'b0;
    wd_ready    = 1'b0;
    rd_valid    = 1'b0;
    rd_last     = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) w_state_nxt = cmd_we ? S_AW : S_AR;
      end
      S_AW: begin
        axi.awvalid = 1'b1;
        if (axi.awready) w_state_nxt = S_W;
      end
      S_W: begin
        axi.wvalid = wd_valid;
        wd_ready   = axi.wready;
        axi.wlast  = w_cnt_at_len;
        if (w_w_hs && w_cnt_at_len) w_state_nxt = S_B;
      end
      S_B: begin
        axi.bready = 1'b1;
        if (axi.bvalid) w_state_nxt = S_IDLE;
      end
      S_AR: begin
        axi.arvalid = 1'b1;
        if (axi.arready) w_state_nxt = S_R;
      end
      S_R: begin
        axi.rready = rd_ready;
        rd_valid   = axi.rvalid;
        rd_last    = axi.rlast;
        if (w_r_exit) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_addr     <= '0;
      r_len      <= '0;
      r_cnt      <= '0;
      r_resp     <= 3'b000;
      r_err_resp <= 3'b000;
      r_err      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_addr     <= cmd_addr;
            r_len      <= cmd_len;
            r_cnt      <= '0;
            r_err      <= 1'b0;
            r_err_resp <= 3'b000;
          end
        end
        S_W: begin
          if (w_w_hs) r_cnt <= w_cnt_at_len ? '0 : r_cnt + LB'(1);
        end
        S_B: begin
          if (axi.bvalid) begin
            r_resp <= axi.bresp;
            r_done <= 1'b1;
          end
        end
        S_R: begin
          if (w_r_hs) begin
            if (!r_err && axi.rresp != 3'b000) begin
              r_err      <= 1'b1;
              r_err_resp <= axi.rresp;
            end
            if (w_r_exit) begin
              r_cnt  <= '0;
              r_resp <= w_r_resp;
              r_done <= 1'b1;
            end else begin
              r_cnt <= r_cnt + LB'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_interface_master.sv
// Bench for axi_interface_master: directed vector table, reset-in-burst sequence and
// randomized bursts against a rule-level model of beat count and completion response.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef LEN_BITS
`define LEN_BITS 8
`endif
`ifndef ID_BITS
`define ID_BITS 4
`endif

module tb_axi_interface_master;
  localparam int AW  = `ADDR_WIDTH;
  localparam int DW  = `DATA_WIDTH;
  localparam int SW  = `DATA_WIDTH/8;
  localparam int LB  = `LEN_BITS;
  localparam int IDB = `ID_BITS;
  localparam int SZ  = $clog2(DW/8);
  localparam int BUDGET = 4000;

  typedef struct {
    bit          we;
    logic [AW-1:0] addr;
    int          len;
    int          aw_delay;
    int          w_stall;
    int          pace;
    int          err_beat;
    logic [2:0]  err_code;
    int          rlast_at;
    logic [2:0]  bresp;
    logic [DW-1:0] data0;
    int          abort_at;
    int          exp_beats;
    logic [2:0]  exp_resp;
    int          exp_lat;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_ni;
  always #5 clk = ~clk;

  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [LB-1:0] cmd_len;
  logic          wd_valid, wd_ready;
  logic [DW-1:0] wd_data;
  logic [SW-1:0] wd_strb;
  logic          rd_valid, rd_ready, rd_last;
  logic [DW-1:0] rd_data;
  logic          done;
  logic [2:0]    resp;
  logic [2:0]    dbg_state;

  axi_interface_master_if axi();

  axi_interface_master dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .done(done), .resp(resp), .dbg_state(dbg_state),
    .axi(axi)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [DW-1:0] rmodel(input logic [AW-1:0] a, input int i);
    return (DW'(a) * DW'(32'h9E37)) + (DW'(i) * DW'(32'h0101_0103)) ^ DW'(32'hC0DE_0000);
  endfunction

  function automatic logic [DW-1:0] wbeat(input logic [DW-1:0] d0, input int i);
    return d0 + DW'(i) * DW'(32'h0101_0101);
  endfunction

  function automatic logic [SW-1:0] wstrb_of(input int i);
    return (i % 3 == 1) ? SW'(5) : {SW{1'b1}};
  endfunction

  // Reference: beats delivered and completion response from the burst rules alone.
  function automatic vec_t ref_model(input vec_t v);
    vec_t o;
    int   last;
    o = v;
    if (v.we) begin
      o.exp_beats = v.len + 1;
      o.exp_resp  = v.bresp;
    end else begin
      last = (v.rlast_at < v.len) ? v.rlast_at : v.len;
      o.exp_beats = last + 1;
      if (v.err_code != 3'b000 && v.err_beat >= 0 && v.err_beat <= last) o.exp_resp = v.err_code;
      else if (v.rlast_at != v.len) o.exp_resp = 3'b010;
      else o.exp_resp = 3'b000;
    end
    return o;
  endfunction

  function automatic vec_t mk(bit we, logic [AW-1:0] addr, int len, int aw_delay, int w_stall,
                              int pace, int err_beat, logic [2:0] err_code, int rlast_at,
                              logic [2:0] bresp, logic [DW-1:0] data0, int abort_at,
                              int exp_beats, logic [2:0] exp_resp, int exp_lat);
    vec_t v;
    v.we = we; v.addr = addr; v.len = len; v.aw_delay = aw_delay; v.w_stall = w_stall;
    v.pace = pace; v.err_beat = err_beat; v.err_code = err_code; v.rlast_at = rlast_at;
    v.bresp = bresp; v.data0 = data0; v.abort_at = abort_at;
    v.exp_beats = exp_beats; v.exp_resp = exp_resp; v.exp_lat = exp_lat;
    return v;
  endfunction

  // driver tasks
  task automatic drive_idle();
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_len = '0;
    wd_valid = 1'b0; wd_data = '0; wd_strb = '0; rd_ready = 1'b0;
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = '0; axi.bid = '0;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = '0; axi.rlast = 1'b0;
    axi.rid = '0;
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    logic [DW-1:0] exp_q[$];
    logic [SW-1:0] exp_s[$];
    logic [DW-1:0] ed;
    logic [SW-1:0] es;
    logic [2:0]    got_resp = 3'b000;
    int  cyc = 0, cmd_cyc = 0, done_cyc = -1;
    int  aw_wait = 0, w_wait = 0, w_beats = 0, r_beats = 0;
    int  bad_aw = 0, bad_w = 0, bad_r = 0, bad_busy = 0;
    bit  taken = 0, addr_hs = 0, addr_pend = 0, b_pend = 0, r_act = 0, fin = 0;
    bit  in_w, in_r, rdy_at_done = 0, a_valid, a_ready;

    for (int i = 0; i <= v.len; i++) begin
      exp_q.push_back(wbeat(v.data0, i));
      exp_s.push_back(wstrb_of(i));
    end

    while (!fin && cyc < BUDGET) begin
      @(negedge clk);
      cmd_valid   = !taken;
      cmd_we      = v.we;
      cmd_addr    = v.addr;
      cmd_len     = LB'(v.len);
      wd_valid    = (w_beats <= v.len) && (v.pace != 2 || $urandom_range(0, 3) != 0);
      wd_data     = wbeat(v.data0, w_beats);
      wd_strb     = wstrb_of(w_beats);
      axi.awready = (aw_wait >= v.aw_delay);
      axi.arready = (aw_wait >= v.aw_delay);
      axi.wready  = (w_wait >= v.w_stall);
      axi.bvalid  = b_pend;
      axi.bresp   = v.bresp;
      axi.rvalid  = r_act && (r_beats <= v.rlast_at);
      axi.rdata   = rmodel(v.addr, r_beats);
      axi.rresp   = (r_beats == v.err_beat) ? v.err_code : 3'b000;
      axi.rlast   = (r_beats == v.rlast_at);
      rd_ready    = (v.pace == 0) ? 1'b1 : (v.pace == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 1) == 1);

      if (v.abort_at >= 0 && taken && addr_hs && w_beats == v.abort_at) begin
        rst_ni = 1'b0;
        #1;
        check({tag, ".rst_awvalid"}, axi.awvalid, 1'b0);
        check({tag, ".rst_wvalid"}, axi.wvalid, 1'b0);
        check({tag, ".rst_bready"}, axi.bready, 1'b0);
        check({tag, ".rst_cmd_ready"}, cmd_ready, 1'b1);
        check({tag, ".rst_done"}, done, 1'b0);
        @(negedge clk);
        drive_idle();
        rst_ni = 1'b1;
        return;
      end
      #1;

      if (cmd_valid && cmd_ready) begin
        taken = 1; cmd_cyc = cyc;
      end else if (taken && cmd_ready && !done) begin
        bad_busy++;
      end

      in_w = v.we && addr_hs && (w_beats <= v.len);
      in_r = !v.we && r_act;

      if (axi.bvalid && axi.bready) b_pend = 0;

      if (rd_valid !== (in_r && axi.rvalid) || axi.rready !== (in_r && rd_ready)) bad_r++;
      if (rd_valid && rd_ready) begin
        if (rd_data !== rmodel(v.addr, r_beats) || rd_last !== (r_beats == v.rlast_at)) bad_r++;
        if (axi.rlast || r_beats == v.len) r_act = 0;
        r_beats++;
      end

      if (axi.wvalid !== (in_w && wd_valid) || wd_ready !== (in_w && axi.wready)) bad_w++;
      if (axi.wvalid && axi.wready) begin
        if (exp_q.size() == 0) bad_w++;
        else begin
          ed = exp_q.pop_front();
          es = exp_s.pop_front();
          if (axi.wdata !== ed || axi.wstrb !== es) bad_w++;
        end
        if (axi.wlast !== (w_beats == v.len)) bad_w++;
        w_beats++; w_wait = 0;
        if (w_beats > v.len) b_pend = 1;
      end else if (axi.wvalid) begin
        w_wait++;
      end

      a_valid = v.we ? axi.awvalid : axi.arvalid;
      a_ready = v.we ? axi.awready : axi.arready;
      if (v.we ? axi.arvalid : axi.awvalid) bad_aw++;
      if (addr_pend && !a_valid) bad_aw++;
      if (addr_hs && a_valid) bad_aw++;
      if (a_valid) begin
        if (v.we) begin
          if (axi.awaddr !== v.addr || axi.awlen !== LB'(v.len) || axi.awsize !== 3'(SZ) ||
              axi.awburst !== 2'b01 || axi.awid !== IDB'(0)) bad_aw++;
        end else begin
          if (axi.araddr !== v.addr || axi.arlen !== LB'(v.len) || axi.arsize !== 3'(SZ) ||
              axi.arburst !== 2'b01 || axi.arid !== IDB'(0)) bad_aw++;
        end
        if (a_ready) begin
          addr_hs = 1; addr_pend = 0;
          if (!v.we) r_act = 1;
        end else begin
          addr_pend = 1; aw_wait++;
        end
      end

      if (done && taken) begin
        fin = 1; done_cyc = cyc - cmd_cyc; got_resp = resp; rdy_at_done = cmd_ready;
      end
      cyc++;
    end

    check({tag, ".done_seen"}, fin, 1'b1);
    check({tag, ".beats"}, v.we ? w_beats : r_beats, v.exp_beats);
    check({tag, ".resp"}, got_resp, v.exp_resp);
    if (v.exp_lat >= 0) check({tag, ".latency"}, done_cyc, v.exp_lat);
    check({tag, ".addr_chan"}, bad_aw, 0);
    check({tag, ".w_path"}, bad_w, 0);
    check({tag, ".r_path"}, bad_r, 0);
    check({tag, ".busy_ready"}, bad_busy, 0);
    check({tag, ".ready_at_done"}, rdy_at_done, 1'b1);
    @(negedge clk);
    drive_idle();
    #1;
    check({tag, ".done_pulse"}, done, 1'b0);
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = mk(1, 'h100,  0,   0, 0, 0, -1, 3'b000, 0,   3'b000, 'hDEADBEEF, -1, 1,   3'b000, 4);
    vecs[1]  = mk(1, 'h200,  3,   3, 2, 0, -1, 3'b000, 3,   3'b000, 'h11110000, -1, 4,   3'b000, -1);
    vecs[2]  = mk(0, 'h40,   7,   0, 0, 1, -1, 3'b000, 7,   3'b000, '0,         -1, 8,   3'b000, -1);
    vecs[3]  = mk(0, 'h80,   3,   0, 0, 0,  1, 3'b010, 3,   3'b000, '0,         -1, 4,   3'b010, -1);
    vecs[4]  = mk(0, 'hC0,   3,   0, 0, 0, -1, 3'b000, 1,   3'b000, '0,         -1, 2,   3'b010, -1);
    vecs[5]  = mk(1, 'h300,  7,   0, 0, 0, -1, 3'b000, 7,   3'b000, 'h55AA0000,  2, 0,   3'b000, -1);
    vecs[6]  = mk(0, 'h400,  0,   0, 0, 0, -1, 3'b000, 0,   3'b000, '0,         -1, 1,   3'b000, 3);
    vecs[7]  = mk(1, 'h500,  1,   1, 0, 0, -1, 3'b000, 1,   3'b010, 'h01020304, -1, 2,   3'b010, -1);
    vecs[8]  = mk(0, 'h600,  1,   0, 0, 0, -1, 3'b000, 3,   3'b000, '0,         -1, 2,   3'b010, -1);
    vecs[9]  = mk(0, 'h700,  3,   2, 0, 2,  0, 3'b011, 1,   3'b000, '0,         -1, 2,   3'b011, -1);
    vecs[10] = mk(1, 'h1000, 255, 0, 0, 0, -1, 3'b000, 255, 3'b000, 'hA0000000, -1, 256, 3'b000, -1);
    vecs[11] = mk(0, 'h2000, 255, 0, 0, 1, -1, 3'b000, 255, 3'b000, '0,         -1, 256, 3'b000, -1);

    rst_ni = 1'b0;
    drive_idle();
    repeat (3) @(negedge clk);
    #1;
    check("reset.cmd_ready", cmd_ready, 1'b1);
    check("reset.done", done, 1'b0);
    check("reset.resp", resp, 3'b000);
    check("reset.awvalid", axi.awvalid, 1'b0);
    check("reset.arvalid", axi.arvalid, 1'b0);
    check("reset.wvalid", axi.wvalid, 1'b0);
    check("reset.bready", axi.bready, 1'b0);
    check("reset.rd_valid", rd_valid, 1'b0);
    check("reset.awaddr", axi.awaddr, '0);
    check("reset.arlen", axi.arlen, '0);
    @(negedge clk);
    rst_ni = 1'b1;

    for (int i = 0; i < 12; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    for (int k = 0; k < 24; k++) begin
      vec_t v;
      v.we       = ($urandom_range(0, 1) == 1);
      v.addr     = AW'($urandom) & ~AW'(3);
      v.len      = $urandom_range(0, 15);
      v.aw_delay = $urandom_range(0, 3);
      v.w_stall  = $urandom_range(0, 2);
      v.pace     = $urandom_range(0, 2);
      v.err_beat = $urandom_range(0, v.len + 1);
      case ($urandom_range(0, 3))
        2:       v.err_code = 3'b010;
        3:       v.err_code = 3'($urandom_range(1, 7));
        default: v.err_code = 3'b000;
      endcase
      v.rlast_at = ($urandom_range(0, 2) != 0) ? v.len : $urandom_range(0, v.len + 3);
      v.bresp    = 3'($urandom_range(0, 7));
      v.data0    = DW'($urandom);
      v.abort_at = -1;
      v.exp_lat  = -1;
      v.exp_beats = 0;
      v.exp_resp  = 3'b000;
      v = ref_model(v);
      run_txn(v, $sformatf("rnd%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/axi_interface_master.md
Name: axi_interface_master

Overview:
- AXI4 initiator engine: converts single-command burst requests from a local client (CPU load/store unit, DMA) into AW/W/B or AR/R transactions toward the interconnect and slave ports such as the SDRAM slave.
- Presents a simple valid/ready command port plus streaming write-data and read-data ports.
- One outstanding transaction at a time; INCR bursts only.

Parameters:
- MASTER_ID, 0, value driven on awid/arid (width `ID_BITS).
- AXSIZE, $clog2(`DATA_WIDTH/8), value driven on awsize/arsize (full-width beats).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  engine idle, command accepted when cmd_valid&cmd_ready
- cmd_we  in  1  1=write burst, 0=read burst
- cmd_addr  in  `ADDR_WIDTH  start byte address
- cmd_len  in  `LEN_BITS  beats minus one (AXI len)
- wd_valid/wd_ready  in/out  1  write-data stream handshake
- wd_data  in  `DATA_WIDTH  write beat
- wd_strb  in  `DATA_WIDTH/8  byte strobes
- rd_valid/rd_ready  out/in  1  read-data stream handshake
- rd_data  out  `DATA_WIDTH  read beat
- rd_last  out  1  final read beat
- done  out  1  one-cycle pulse at transaction completion
- resp  out  3  bresp, or first non-zero rresp of the burst (else 0), valid with done
- AXI master side: awid awaddr awlen awsize awburst awvalid awready, wdata wstrb wvalid wlast wready, bid bresp bvalid bready, arid araddr arlen arburst arsize arvalid arready, rid rdata rresp rvalid rlast rready. Widths are the same defines as the slave side; bresp/rresp are 3 bits.

Behaviour:
- Reset (async assert, sync release): state=IDLE; all valid outputs, done and resp are 0; cmd_ready=1; beat counter 0; addr/len/id registers 0.
- FSM states: IDLE, AW, W, B, AR, R.
- IDLE: cmd_ready=1. On a cmd handshake, latch addr/len/we and go to AW (we=1) or AR (we=0). cmd_ready=0 in all other states.
- AW/AR: awvalid/arvalid=1 from the cycle after acceptance. Fields are constant while valid: addr, len, size=AXSIZE, burst=2'b01, id=MASTER_ID. Hold until ready, then go to W / R.
- Valid must never be dropped before its handshake. Address fields must not change while valid is high.
- W: wvalid=wd_valid, wready passthrough to wd_ready, wdata/wstrb=wd_data/wd_strb (combinational passthrough). wlast=1 when beat counter==len. Counter increments on each wvalid&wready. After the last beat handshake go to B; counter resets to 0.
- B: bready=1. On bvalid, capture bresp into resp, pulse done for one cycle, return to IDLE.
- R: rready=rd_ready, rd_valid=rvalid, rd_data=rdata, rd_last=rlast, all passthrough. Beat counter counts handshakes. Any non-zero rresp is latched as the sticky first error.
- R exits on the handshake of the beat where rlast=1, OR where counter==len, whichever comes first. At exit, done pulses.
  - If the rlast position disagrees with len (early or missing rlast), resp is forced to 3'b010 (SLVERR) unless an error is already latched.
- Latency: command accepted at cycle 0, awvalid/arvalid high at cycle 1. Minimum single-beat write with slave always ready: done at cycle 4. Minimum single-beat read: done at cycle 3.
- Next command can be accepted the cycle after done (cmd_ready returns with IDLE).
- bid/rid are not checked; single outstanding transaction.
- cmd_valid while busy: ignored and not queued; the client holds it.
- len=0: single beat, wlast on the first beat.
- len=max (255 for 8-bit len): counter width `LEN_BITS, no wrap before the last beat.
- Reset mid-burst: immediate return to IDLE, all valids low. No recovery of the in-flight AXI transaction is required.

Test Plan:
1. Single write: cmd addr=0x100, len=0, data=0xDEADBEEF, strb=all-ones, slave always ready -> awaddr=0x100, awlen=0, awburst=01, one W beat with wlast=1, bready=1, done at cycle 4, resp=0.
2. 4-beat write with wready stalled 2 cycles per beat and awready delayed 3 cycles -> awvalid held steady; exactly 4 W beats; wlast only on beat 4; done after bvalid.
3. 8-beat read, addr=0x40, rd_ready toggled 1/0 -> arlen=7; 8 rd beats delivered in order with data matching the slave model; rd_last on beat 8; done with resp=0.
4. Read where the slave returns rresp=3'b010 on beat 2 of 4 and 0 elsewhere -> all 4 beats delivered; resp=3'b010 at done.
5. Read len=3 where the slave asserts rlast on beat 2 -> exit after beat 2; done pulses; resp=3'b010.
6. Assert rst_ni low during beat 3 of an 8-beat write -> awvalid/wvalid/bready=0 and cmd_ready=1 immediately. After release, a new single read completes normally.
